// File: rtl/rtc_bus_sequencer.sv
// Multiplexed address/data RTC bus sequencer: sweeps NUM_REGS registers into a shadow file
// and interleaves user writes. Optional BCD validation of read bytes under BCD_CHECK_EN.
module rtc_bus_sequencer #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_REGS  = 9,
    parameter int unsigned BASE_ADDR = 'h21,
    parameter int unsigned T_PHASE   = 4,
    parameter int unsigned SWEEP_GAP = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [3:0]        wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic [3:0]        rd_idx,
    output logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] chip_out,
    output logic [DATA_W-1:0] chip_in,
    output logic              bus_oe,
    output logic [3:0]        control_chip,
    output logic [4:0]        cuenta_lectura,
    output logic              sweep_done,
`ifdef BCD_CHECK_EN
    output logic              bcd_err,
`endif
    output logic              busy
);

    localparam int unsigned PH_W  = $clog2(T_PHASE + 1);
    localparam int unsigned GAP_W = $clog2(SWEEP_GAP + 1);
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 5;

    // {cs_n, rd_n, wr_n, ad}
    localparam logic [3:0] CTRL_IDLE = 4'b1110;
    localparam logic [3:0] CTRL_ADDR = 4'b0111;
    localparam logic [3:0] CTRL_ASTB = 4'b0101;
    localparam logic [3:0] CTRL_DATA = 4'b0110;
    localparam logic [3:0] CTRL_WSTB = 4'b0100;
    localparam logic [3:0] CTRL_RSTB = 4'b0010;

    typedef enum logic [2:0] {
        S_IDLE, S_A_SETUP, S_A_STROBE, S_A_HOLD, S_D_SETUP, S_D_STROBE, S_D_HOLD, S_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                is_wr_q, is_wr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wr_ack_q, wr_ack_d;
    logic                done_q, done_d;
    logic [3:0]          ctrl_q, ctrl_d;
    logic [DATA_W-1:0]   chin_q, chin_d;
    logic                oe_q, oe_d;
    logic [CNT_W-1:0]    cuenta_q, cuenta_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   addr_c;
    logic                phase_end;
    logic                store_rd, store_wr;
    logic                rd_ok;
    logic [DATA_W-1:0]   shadow_q [NUM_REGS];

    assign phase_end = (ph_q == PH_W'(T_PHASE - 1));

`ifdef BCD_CHECK_EN
    assign rd_ok = (chip_out[7:4] <= 4'd9) && (chip_out[3:0] <= 4'd9);
`else
    assign rd_ok = 1'b1;
`endif

    // State, phase timer, arbitration and registered bus outputs decoded from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            ph_q     <= '0;
            gap_q    <= GAP_W'(SWEEP_GAP);
            idx_q    <= '0;
            is_wr_q  <= 1'b0;
            wdata_q  <= '0;
            wr_ack_q <= 1'b0;
            done_q   <= 1'b0;
            ctrl_q   <= CTRL_IDLE;
            chin_q   <= '0;
            oe_q     <= 1'b0;
            cuenta_q <= CNT_W'(31);
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            gap_q    <= gap_d;
            idx_q    <= idx_d;
            is_wr_q  <= is_wr_d;
            wdata_q  <= wdata_d;
            wr_ack_q <= wr_ack_d;
            done_q   <= done_d;
            ctrl_q   <= ctrl_d;
            chin_q   <= chin_d;
            oe_q     <= oe_d;
            cuenta_q <= cuenta_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        gap_d    = gap_q;
        idx_d    = idx_q;
        is_wr_d  = is_wr_q;
        wdata_d  = wdata_q;
        wr_ack_d = 1'b0;
        done_d   = 1'b0;
        store_rd = 1'b0;
        store_wr = 1'b0;

        if (state_q != S_IDLE) ph_d = phase_end ? '0 : ph_q + PH_W'(1);
        if (state_q == S_IDLE && gap_q != '0) gap_d = gap_q - GAP_W'(1);

        case (state_q)
            S_IDLE: begin
                // wr_ack_q blocks re-accepting a request still held during its own ack cycle
                if (wr_req && !wr_ack_q) begin
                    state_d = S_A_SETUP;
                    ph_d    = '0;
                    is_wr_d = 1'b1;
                    idx_d   = wr_idx;
                    wdata_d = wr_data;
                end else if (gap_q <= GAP_W'(1)) begin
                    state_d = S_A_SETUP;
                    ph_d    = '0;
                    is_wr_d = 1'b0;
                    idx_d   = '0;
                end
            end
            S_GAP: begin
                if (phase_end) begin
                    if (is_wr_q) begin
                        wr_ack_d = 1'b1;
                        store_wr = 1'b1;
                        state_d  = S_IDLE;
                    end else if (idx_q == IDX_W'(NUM_REGS - 1)) begin
                        done_d  = 1'b1;
                        gap_d   = GAP_W'(SWEEP_GAP);
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_A_SETUP;
                    end
                end
            end
            default: begin
                if (phase_end) begin
                    store_rd = (state_q == S_D_STROBE) && !is_wr_q;
                    state_d  = state_t'(state_q + 3'd1);
                end
            end
        endcase

        addr_c   = DATA_W'(BASE_ADDR) + DATA_W'(idx_d);
        ctrl_d   = CTRL_IDLE;
        chin_d   = '0;
        oe_d     = 1'b0;
        cuenta_d = CNT_W'(31);
        busy_d   = (state_d != S_IDLE);
        case (state_d)
            S_A_SETUP, S_A_HOLD: begin
                ctrl_d = CTRL_ADDR;
                oe_d   = 1'b1;
                chin_d = addr_c;
            end
            S_A_STROBE: begin
                ctrl_d = CTRL_ASTB;
                oe_d   = 1'b1;
                chin_d = addr_c;
            end
            S_D_SETUP, S_D_HOLD: begin
                ctrl_d = CTRL_DATA;
                oe_d   = is_wr_d;
                chin_d = is_wr_d ? wdata_d : '0;
            end
            S_D_STROBE: begin
                ctrl_d = is_wr_d ? CTRL_WSTB : CTRL_RSTB;
                oe_d   = is_wr_d;
                chin_d = is_wr_d ? wdata_d : '0;
            end
            default: ;
        endcase
        if (state_d != S_IDLE && !is_wr_d) cuenta_d = CNT_W'(idx_d);
    end

    // Shadow file: reads land at the end of D_STROBE, writes at GAP exit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    if (store_rd && rd_ok) shadow_q[i] <= chip_out;
                    else if (store_wr)     shadow_q[i] <= wdata_q;
                end
            end
        end
    end

`ifdef BCD_CHECK_EN
    logic bcd_err_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bcd_err_q <= 1'b0;
        else if (store_rd && !rd_ok) bcd_err_q <= 1'b1;
    end
    assign bcd_err = bcd_err_q;
`endif

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) rd_data = shadow_q[i];
        end
    end

    assign wr_ack         = wr_ack_q;
    assign sweep_done     = done_q;
    assign control_chip   = ctrl_q;
    assign chip_in        = chin_q;
    assign bus_oe         = oe_q;
    assign cuenta_lectura = cuenta_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: RTC bus model plus a queue of expected bus transactions.
`timescale 1ns/1ps
module tb_rtc_bus_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_req;
    logic [3:0] wr_idx;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic [3:0] rd_idx;
    logic [7:0] rd_data;
    logic [7:0] chip_out;
    logic [7:0] chip_in;
    logic       bus_oe;
    logic [3:0] control_chip;
    logic [4:0] cuenta_lectura;
    logic       sweep_done;
    logic       busy;
`ifdef BCD_CHECK_EN
    logic       bcd_err;
`endif

    int checks = 0;
    int errors = 0;
    int n;
    logic acked;
    logic inject = 1'b0;
    logic [7:0] lat_addr = 8'h00;
    logic [3:0] prev_ctrl = 4'b1110;
    logic [7:0] mon_addr = 8'h00;

    typedef struct packed {
        logic       is_wr;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;
    txn_t exp_q[$];

    always #50 clk = ~clk;

    rtc_bus_sequencer #(
        .DATA_W(8), .NUM_REGS(9), .BASE_ADDR('h21), .T_PHASE(2), .SWEEP_GAP(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_req(wr_req),
        .wr_idx(wr_idx),
        .wr_data(wr_data),
        .wr_ack(wr_ack),
        .rd_idx(rd_idx),
        .rd_data(rd_data),
        .chip_out(chip_out),
        .chip_in(chip_in),
        .bus_oe(bus_oe),
        .control_chip(control_chip),
        .cuenta_lectura(cuenta_lectura),
        .sweep_done(sweep_done),
`ifdef BCD_CHECK_EN
        .bcd_err(bcd_err),
`endif
        .busy(busy)
    );

    function automatic logic [7:0] rtc_val(input logic [7:0] a);
`ifdef BCD_CHECK_EN
        return {4'h5, a[3:0]};
`else
        return a ^ 8'hFF;
`endif
    endfunction

    // RTC model: latch the address on the address strobe, return its register value
    always @(posedge clk) if (control_chip == 4'b0101) lat_addr <= chip_in;
    always_comb chip_out = (inject && lat_addr == 8'h22) ? 8'h3A : rtc_val(lat_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic mon_check(input logic is_wr, input logic [7:0] addr, input logic [7:0] din,
                             input logic [4:0] idx, input logic oe);
        txn_t obs;
        txn_t expd;
        obs.is_wr = is_wr;
        obs.addr  = addr;
        obs.data  = is_wr ? din : {3'b000, idx};
        chk("txn_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            expd = exp_q.pop_front();
            chk("txn", 32'(obs), 32'(expd));
        end
        chk("txn_bus_oe", 32'(oe), 32'(is_wr));
        if (is_wr) chk("txn_wr_cuenta", 32'(idx), 32'd31);
    endtask

    // Bus monitor: one scoreboard pop at the first cycle of every data strobe
    always @(negedge clk) begin
        if (rst && control_chip == 4'b0101 && prev_ctrl != 4'b0101) mon_addr <= chip_in;
        if (rst && (control_chip == 4'b0100 || control_chip == 4'b0010) && prev_ctrl != control_chip)
            mon_check(control_chip == 4'b0100, mon_addr, chip_in, cuenta_lectura, bus_oe);
        prev_ctrl <= control_chip;
    end

    task automatic push_txn(input logic is_wr, input logic [7:0] addr, input logic [7:0] data);
        txn_t t;
        t.is_wr = is_wr;
        t.addr  = addr;
        t.data  = data;
        exp_q.push_back(t);
    endtask

    task automatic push_sweep();
        for (int i = 0; i < 9; i++) push_txn(1'b0, 8'(8'h21 + i), 8'(i));
    endtask

    function automatic logic sig(input int which);
        case (which)
            0: return busy;
            1: return sweep_done;
            2: return wr_ack;
            3: return control_chip == 4'b0010;
            4: return cuenta_lectura == 5'd2;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int which, input int bound, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!sig(which) && cnt < bound);
        chk(tag, 32'(sig(which)), 32'd1);
    endtask

    task automatic chk_shadow(input logic zero);
        logic [7:0] e;
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            #1;
            e = (i < 9 && !zero) ? rtc_val(8'(8'h21 + i)) : 8'h00;
            chk($sformatf("shadow[%0d]", i), 32'(rd_data), 32'(e));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; wr_req = 1'b0; wr_idx = 4'd0; wr_data = 8'h00; rd_idx = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_control", 32'(control_chip), 32'hE);
        chk("rst_chip_in", 32'(chip_in), 32'h0);
        chk("rst_bus_oe", 32'(bus_oe), 32'h0);
        chk("rst_wr_ack", 32'(wr_ack), 32'h0);
        chk("rst_sweep_done", 32'(sweep_done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cuenta", 32'(cuenta_lectura), 32'd31);
`ifdef BCD_CHECK_EN
        chk("rst_bcd_err", 32'(bcd_err), 32'h0);
`endif
        chk_shadow(1'b1);

        // First sweep after a 10-cycle idle gap
        push_sweep();
        @(negedge clk);
        rst = 1'b1;
        wait_sig("gap_busy_seen", 0, 50, n);
        chk("gap_len", 32'(n), 32'd10);
        wait_sig("sweep_done_seen", 1, 300, n);
        chk("sweep_len", 32'(n), 32'd126);
        chk("done_busy", 32'(busy), 32'h0);
        chk("done_cuenta", 32'(cuenta_lectura), 32'd31);
        @(negedge clk);
        chk("done_pulse_width", 32'(sweep_done), 32'h0);
        chk_shadow(1'b0);

        // Write from IDLE
        wr_idx = 4'd3; wr_data = 8'h45; wr_req = 1'b1;
        push_txn(1'b1, 8'h24, 8'h45);
        wait_sig("wr_busy_seen", 0, 5, n);
        chk("wr_accept_lat", 32'(n), 32'd1);
        wait_sig("wr_ack_seen", 2, 40, n);
        chk("wr_len", 32'(n), 32'd14);
        rd_idx = 4'd3; #1;
        chk("wr_shadow3", 32'(rd_data), 32'h45);
        wr_req = 1'b0;
        @(negedge clk);
        chk("wr_ack_width", 32'(wr_ack), 32'h0);
        chk("wr_no_reaccept", 32'(busy), 32'h0);

        // Write raised during sweep index 2 waits for sweep_done
        push_sweep();
        wait_sig("idx2_seen", 4, 100, n);
        wr_idx = 4'd5; wr_data = 8'h77; wr_req = 1'b1;
        push_txn(1'b1, 8'h26, 8'h77);
        n = 0; acked = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (wr_ack) acked = 1'b1;
        end while (!sweep_done && n < 200);
        chk("ack_before_done", 32'(acked), 32'h0);
        chk("mid_done_seen", 32'(sweep_done), 32'h1);
        @(negedge clk);
        chk("mid_wr_start", 32'(busy), 32'h1);
        chk("mid_wr_cuenta", 32'(cuenta_lectura), 32'd31);
        wait_sig("mid_ack_seen", 2, 40, n);
        chk("mid_wr_len", 32'(n), 32'd14);
        rd_idx = 4'd5; #1;
        chk("mid_shadow5", 32'(rd_data), 32'h77);
        rd_idx = 4'd3; #1;
        chk("mid_shadow3", 32'(rd_data), 32'(rtc_val(8'h24)));
        wr_req = 1'b0;

        // Reset during a read data strobe
        push_txn(1'b0, 8'h21, 8'h00);
        wait_sig("rd_strobe_seen", 3, 100, n);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_control", 32'(control_chip), 32'h E);
        chk("arst_bus_oe", 32'(bus_oe), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_cuenta", 32'(cuenta_lectura), 32'd31);
        chk("arst_queue", 32'(exp_q.size()), 32'd0);
        chk_shadow(1'b1);

        // Write and gap expiry on the same cycle; out-of-range index
        wr_idx = 4'd12; wr_data = 8'hA5;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (9) @(negedge clk);
        wr_req = 1'b1;
        push_txn(1'b1, 8'h2D, 8'hA5);
        push_sweep();
        @(negedge clk);
        chk("coin_wr_first", 32'(busy), 32'h1);
        chk("coin_wr_cuenta", 32'(cuenta_lectura), 32'd31);
        wait_sig("coin_ack_seen", 2, 40, n);
        chk("coin_wr_len", 32'(n), 32'd14);
        rd_idx = 4'd12; #1;
        chk("coin_shadow12", 32'(rd_data), 32'h0);
        wr_req = 1'b0;
        @(negedge clk);
        chk("coin_sweep_busy", 32'(busy), 32'h1);
        chk("coin_sweep_idx0", 32'(cuenta_lectura), 32'd0);
        wait_sig("coin_done_seen", 1, 300, n);
        chk("coin_queue", 32'(exp_q.size()), 32'd0);
        chk_shadow(1'b0);

`ifdef BCD_CHECK_EN
        chk("bcd_clean", 32'(bcd_err), 32'h0);
        inject = 1'b1;
        push_sweep();
        wait_sig("bcd_done1", 1, 400, n);
        rd_idx = 4'd1; #1;
        chk("bcd_shadow1_kept", 32'(rd_data), 32'(rtc_val(8'h22)));
        chk("bcd_err_set", 32'(bcd_err), 32'h1);
        inject = 1'b0;
        push_sweep();
        wait_sig("bcd_done2", 1, 400, n);
        chk("bcd_err_sticky", 32'(bcd_err), 32'h1);
        chk_shadow(1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
